// File: rtl/rr_packet_mux_2x1.sv
// Two-channel valid/ready packet multiplexer with round-robin arbitration.
// Grant is held for a whole packet; the selected beat and its source are registered.
module rr_packet_mux_2x1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             out_sel,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             out_sel_q, out_sel_d;

    logic             grant;
    logic             grant_valid;
    logic             load_en;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    // While locked only the owner may be granted, even if it has nothing to send.
    always_comb begin
        grant       = 1'b0;
        grant_valid = 1'b0;
        if (state_q == IDLE) begin
            if (in0_valid && in1_valid) begin
                grant       = prio_q;
                grant_valid = 1'b1;
            end else if (in0_valid) begin
                grant       = 1'b0;
                grant_valid = 1'b1;
            end else if (in1_valid) begin
                grant       = 1'b1;
                grant_valid = 1'b1;
            end
        end else begin
            grant       = owner_q;
            grant_valid = owner_q ? in1_valid : in0_valid;
        end
    end

    assign load_en   = !out_valid_q || out_ready;
    assign accept    = grant_valid && load_en && !rst;
    assign in0_ready = accept && (grant == 1'b0);
    assign in1_ready = accept && (grant == 1'b1);
    assign sel_data  = grant ? in1_data : in0_data;
    assign sel_last  = grant ? in1_last : in0_last;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_sel_d   = grant;
            out_valid_d = 1'b1;
            if (sel_last) begin
                state_d = IDLE;
                prio_d  = ~grant;
            end else if (state_q == IDLE) begin
                state_d = LOCK;
                owner_d = grant;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            prio_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            prio_q      <= prio_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;
    assign busy      = (state_q == LOCK);

endmodule

// File: tb/tb_rr_packet_mux_2x1.sv
// Directed scenario bench for rr_packet_mux_2x1; each task checks its own expected values.
module tb_rr_packet_mux_2x1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in0_data, in1_data, out_data;
    logic       in0_valid, in0_last, in0_ready;
    logic       in1_valid, in1_last, in1_ready;
    logic       out_valid, out_last, out_ready, out_sel, busy;

    int vectors    = 0;
    int miscompares = 0;

    rr_packet_mux_2x1 #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_last(in0_last), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_last(in1_last), .in1_ready(in1_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .out_sel(out_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    // Observed output word: {out_valid, out_sel, out_last, busy, out_data}
    function automatic logic [11:0] obs();
        return {out_valid, out_sel, out_last, busy, out_data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in0_data = 8'h00; in1_data = 8'h00;
        in0_valid = 1'b0; in1_valid = 1'b0; in0_last = 1'b0; in1_last = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        in0_valid = 1'b1; in1_valid = 1'b1;
        #1;
        vectors++;
        if ({in0_ready, in1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 00", {in0_ready, in1_ready});
        end
        step();
        vectors++;
        if (obs() !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 000", obs());
        end
        rst = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0;
    endtask

    task automatic test_alternate();
        logic [11:0] exp;
        in0_valid = 1'b1; in1_valid = 1'b1; in0_last = 1'b1; in1_last = 1'b1;
        in0_data = 8'h10; in1_data = 8'h20;
        for (int i = 0; i < 6; i++) begin
            #1;
            vectors++;
            if ({in0_ready, in1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL alt_ready[%0d]: got %b", i, {in0_ready, in1_ready});
            end
            step();
            exp = (i % 2 == 0) ? {4'b1010, 8'h10} : {4'b1110, 8'h20};
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL alt_beat[%0d]: got %h expected %h", i, obs(), exp);
            end
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL alt_drain: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_lock();
        logic [7:0]  beats [3];
        logic [11:0] exp;
        beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
        in1_valid = 1'b1; in1_data = 8'hB1; in1_last = 1'b1;
        in0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in0_data = beats[i];
            in0_last = (i == 2);
            #1;
            vectors++;
            if ({in0_ready, in1_ready} !== 2'b10) begin
                miscompares++;
                $display("FAIL lock_ready[%0d]: got %b expected 10", i, {in0_ready, in1_ready});
            end
            step();
            exp = (i == 2) ? {4'b1010, beats[i]} : {4'b1001, beats[i]};
            vectors++;
            if (obs() !== exp) begin
                miscompares++;
                $display("FAIL lock_beat[%0d]: got %h expected %h", i, obs(), exp);
            end
        end
        in0_valid = 1'b0;
        step();
        vectors++;
        if (obs() !== {4'b1110, 8'hB1}) begin
            miscompares++;
            $display("FAIL lock_after: got %h expected eb1", obs());
        end
        in1_valid = 1'b0;
        step();
    endtask

    task automatic test_bubble();
        in0_valid = 1'b1; in0_data = 8'hC1; in0_last = 1'b0;
        in1_valid = 1'b1; in1_data = 8'hD1; in1_last = 1'b1;
        step();
        vectors++;
        if (obs() !== {4'b1001, 8'hC1}) begin
            miscompares++;
            $display("FAIL bubble_first: got %h expected 9c1", obs());
        end
        in0_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (in1_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bubble_block[%0d]: in1_ready got %b expected 0", i, in1_ready);
            end
            step();
            vectors++;
            if ({out_valid, busy} !== 2'b01) begin
                miscompares++;
                $display("FAIL bubble_gap[%0d]: valid/busy got %b expected 01", i, {out_valid, busy});
            end
        end
        in0_valid = 1'b1; in0_data = 8'hC2; in0_last = 1'b1;
        step();
        vectors++;
        if (obs() !== {4'b1010, 8'hC2}) begin
            miscompares++;
            $display("FAIL bubble_resume: got %h expected ac2", obs());
        end
        in0_valid = 1'b0;
        step();
        vectors++;
        if (obs() !== {4'b1110, 8'hD1}) begin
            miscompares++;
            $display("FAIL bubble_other: got %h expected ed1", obs());
        end
        in1_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        in0_valid = 1'b1; in0_data = 8'hE1; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'hF1; in1_last = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if ({in0_ready, in1_ready} !== 2'b00) begin
                miscompares++;
                $display("FAIL bp_ready[%0d]: got %b expected 00", i, {in0_ready, in1_ready});
            end
            step();
            vectors++;
            if (obs() !== {4'b1010, 8'hE1}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got %h expected ae1", i, obs());
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if ({in0_ready, in1_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_release_ready: got %b expected 01", {in0_ready, in1_ready});
        end
        step();
        vectors++;
        if (obs() !== {4'b1110, 8'hF1}) begin
            miscompares++;
            $display("FAIL bp_release: got %h expected ef1", obs());
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        step();
    endtask

    task automatic test_ch1_only();
        in0_valid = 1'b0;
        in1_valid = 1'b1; in1_last = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in1_data = 8'(i);
            step();
            vectors++;
            if (obs() !== {4'b1110, 8'(i)}) begin
                miscompares++;
                $display("FAIL ch1_beat[%0d]: got %h expected %h", i, obs(), {4'b1110, 8'(i)});
            end
        end
        in0_valid = 1'b1; in0_data = 8'h55; in0_last = 1'b1;
        in1_data = 8'h66;
        #1;
        vectors++;
        if ({in0_ready, in1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL ch1_then_both_ready: got %b expected 10", {in0_ready, in1_ready});
        end
        step();
        vectors++;
        if (obs() !== {4'b1010, 8'h55}) begin
            miscompares++;
            $display("FAIL ch1_then_both: got %h expected a55", obs());
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_packet();
        in0_valid = 1'b1; in0_data = 8'h71; in0_last = 1'b0;
        step();
        vectors++;
        if (obs() !== {4'b1001, 8'h71}) begin
            miscompares++;
            $display("FAIL rstmid_lock: got %h expected 971", obs());
        end
        rst = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h81; in1_last = 1'b1;
        step();
        vectors++;
        if ({out_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_clear: valid/busy got %b expected 00", {out_valid, busy});
        end
        rst = 1'b0;
        in0_data = 8'h72; in0_last = 1'b1;
        #1;
        vectors++;
        if ({in0_ready, in1_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL rstmid_ready: got %b expected 10", {in0_ready, in1_ready});
        end
        step();
        vectors++;
        if (obs() !== {4'b1010, 8'h72}) begin
            miscompares++;
            $display("FAIL rstmid_restart: got %h expected a72", obs());
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_lock();
        test_bubble();
        test_backpressure();
        test_ch1_only();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
